apb_vgachargen_bridge: RTL
==========================

// Module: apb_vgachargen_bridge
// PURPOSE
//  APB3 slave placed directly upstream of the VGA text-mode wrapper; translates CPU word accesses
//  into the wrapper's char-map, colour-map and 128-bit char-table memory ports. Hides sync-RAM read
//  latency with wait states; performs read-modify-write so the 128-bit glyph table is writable in 32-bit words.
// PARAMETERS
//  RD_LATENCY  1   cycles from address presented on a map/table port to valid read data (1..4)
// PORTS
//  clk_i            in   1    system clock (same clock as wrapper clk_i)
//  rst_ni           in   1    asynchronous, active-low reset
//  paddr_i          in   16   APB byte address; [15:14] region, [1:0] ignored
//  psel_i           in   1    APB select
//  penable_i        in   1    APB enable (access phase)
//  pwrite_i         in   1    1 = write
//  pwdata_i         in   32   write data
//  prdata_o         out  32   read data, valid while pready_o=1 on a read
//  pready_o         out  1    transfer complete
//  pslverr_o        out  1    transfer error (see CONFIGURATION)
//  ch_map_addr_o    out  12   char-map index;  ch_map_data_o out 8; ch_map_wen_o out 1; ch_map_data_i in 8
//  col_map_addr_o   out  12   colour-map index; col_map_data_o out 8; col_map_wen_o out 1; col_map_data_i in 8
//  ch_t_rw_addr_o   out  7    glyph index; ch_t_rw_data_o out 128; ch_t_rw_wen_o out 1; ch_t_rw_data_i in 128
// BEHAVIOUR
//  - Map: 00=char map (idx=paddr[13:2], valid <2400), 01=colour map (same), 10=char table
//    (glyph=paddr[10:4], word=paddr[3:2], word0=bits[31:0]; valid iff paddr[13:11]==0), 11=invalid.
//  - FSM states IDLE, MAP_WR, RD_WAIT, RESP, CT_WR, ERR. Only IDLE samples APB.
//  - IDLE: on psel_i & ~penable_i (setup) latch paddr/pwdata/pwrite, decode, next state:
//    invalid->ERR; map write->MAP_WR; map read or any char-table access->RD_WAIT.
//  - MAP_WR (1 cyc): addressed wen_o=1, data_o=pwdata[7:0]; pready_o=1 -> IDLE. Zero wait states.
//  - RD_WAIT: lasts exactly RD_LATENCY cycles (counter), address held; -> RESP (read) or CT_WR (table write).
//  - RESP (1 cyc): prdata_o = zero-extended map byte, or selected 32-bit word of ch_t_rw_data_i; pready_o=1 -> IDLE.
//  - CT_WR (1 cyc): ch_t_rw_data_o = ch_t_rw_data_i with selected word replaced by pwdata; ch_t_rw_wen_o=1;
//    pready_o=1 -> IDLE.
//  - ERR (1 cyc): pready_o=1, no wen; prdata_o=0 -> IDLE.
//  - Latency (setup to pready): map write 2 cyc; read / table write 2+RD_LATENCY cyc.
//  - All address/data outputs driven from latched request; held stable through whole transfer.
//  - Outputs at reset and in IDLE: pready_o=0, pslverr_o=0, prdata_o=0, all wen_o=0, addr/data_o=0.
//  - At most one wen_o high in any cycle; each wen_o high for exactly one cycle per write.
//  - Back-to-back: new setup accepted in the cycle immediately after the pready cycle.
//  - psel_i dropped mid-transfer (protocol violation): in-flight operation completes, returns to IDLE.
//  - Setup with penable_i already high in IDLE: ignored.
//  - Reset mid-transfer: immediate IDLE, wen_o deassert asynchronously; glyph never partially written.
// CONFIGURATION
//  APB_VGACHARGEN_SLVERR_EN defined: pslverr_o=1 together with pready_o in ERR.
//  Not defined: pslverr_o tied 0; invalid writes silently dropped, invalid reads return 0.
// TESTING
//  1 Write 0x41 to 0x0004 -> ch_map_wen_o=1 for 1 cyc, addr=1, data=0x41; pready 2 cyc after setup.
//  2 Read 0x4000 after colour write 0x1F (RD_LATENCY=1) -> pready in 3rd cyc, prdata=0x0000001F, no wen.
//  3 Write 0xDEADBEEF to 0x8008 (glyph0, word2), glyph preloaded all-ones -> ch_t_rw_data_o =
//    0xFFFFFFFF_DEADBEEF_FFFFFFFF_FFFFFFFF, wen 1 cyc; read back 0x8008 -> 0xDEADBEEF.
//  4 Access 0x2580 (idx 2400) and 0xC000 -> pready 2 cyc after setup, no wen, prdata=0;
//    pslverr=1 only with APB_VGACHARGEN_SLVERR_EN.
//  5 rst_ni low in CT_WR cycle -> wen low immediately; after release, glyph content unchanged, next transfer OK.
//  6 Back-to-back write 0x0000 then read 0x0000, RD_LATENCY=3 -> read returns written byte, 5 cyc latency.

Source files
------------

// File: rtl/apb_vgachargen_bridge.sv
// APB3 slave mapping CPU word accesses onto the VGA text-mode char map, colour map and glyph table.
// Define APB_VGACHARGEN_SLVERR_EN to flag decode errors on pslverr_o.
module apb_vgachargen_bridge #(
  parameter int RD_LATENCY = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [15:0]  paddr_i,
  input  logic         psel_i,
  input  logic         penable_i,
  input  logic         pwrite_i,
  input  logic [31:0]  pwdata_i,
  output logic [31:0]  prdata_o,
  output logic         pready_o,
  output logic         pslverr_o,
  output logic [11:0]  ch_map_addr_o,
  output logic [7:0]   ch_map_data_o,
  output logic         ch_map_wen_o,
  input  logic [7:0]   ch_map_data_i,
  output logic [11:0]  col_map_addr_o,
  output logic [7:0]   col_map_data_o,
  output logic         col_map_wen_o,
  input  logic [7:0]   col_map_data_i,
  output logic [6:0]   ch_t_rw_addr_o,
  output logic [127:0] ch_t_rw_data_o,
  output logic         ch_t_rw_wen_o,
  input  logic [127:0] ch_t_rw_data_i
);

  typedef enum logic [2:0] {
    IDLE, MAP_WR, RD_WAIT, RESP, CT_WR, ERR
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
`ifdef APB_VGACHARGEN_SLVERR_EN
  localparam logic SLVERR = 1'b1;
`else
  localparam logic SLVERR = 1'b0;
`endif

  state_t       state, state_nx;
  logic [1:0]   cnt, cnt_nx;
  logic [15:2]  addr;
  logic [31:0]  wdata;
  logic         write;
  logic         setup, hit, active;
  logic [1:0]   rgn;
  logic [11:0]  idx;
  logic [6:0]   glyph;
  logic [6:0]   lsb;
  logic [127:0] merged;
  logic         unused_lsb;

  assign setup      = psel_i & ~penable_i;
  assign unused_lsb = ^paddr_i[1:0];
  assign rgn        = addr[15:14];
  assign idx        = addr[13:2];
  assign glyph      = addr[10:4];
  assign lsb        = {addr[3:2], 5'd0};
  assign active     = (state != IDLE) && (state != ERR);

  always_comb begin
    hit = 1'b0;
    unique case (paddr_i[15:14])
      2'b00, 2'b01: hit = paddr_i[13:2] < 12'd2400;
      2'b10:        hit = paddr_i[13:11] == 3'b000;
      default:      hit = 1'b0;
    endcase
  end

  // Glyph merge: untouched words come from the read issued in RD_WAIT.
  always_comb begin
    merged = ch_t_rw_data_i;
    merged[lsb +: 32] = wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      wdata <= '0;
      write <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && setup) begin
        addr  <= paddr_i[15:2];
        wdata <= pwdata_i;
        write <= pwrite_i;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    prdata_o       = '0;
    pready_o       = 1'b0;
    pslverr_o      = 1'b0;
    ch_map_addr_o  = '0;
    ch_map_data_o  = '0;
    ch_map_wen_o   = 1'b0;
    col_map_addr_o = '0;
    col_map_data_o = '0;
    col_map_wen_o  = 1'b0;
    ch_t_rw_addr_o = '0;
    ch_t_rw_data_o = '0;
    ch_t_rw_wen_o  = 1'b0;

    if (active) begin
      unique case (rgn)
        2'b00:   ch_map_addr_o  = idx;
        2'b01:   col_map_addr_o = idx;
        2'b10:   ch_t_rw_addr_o = glyph;
        default: ;
      endcase
    end

    unique case (state)
      IDLE: begin
        if (setup) begin
          if (!hit) begin
            state_nx = ERR;
          end else if (pwrite_i && paddr_i[15:14] != 2'b10) begin
            state_nx = MAP_WR;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = LAT_LAST;
          end
        end
      end
      MAP_WR: begin
        if (rgn == 2'b00) begin
          ch_map_wen_o  = 1'b1;
          ch_map_data_o = wdata[7:0];
        end else begin
          col_map_wen_o  = 1'b1;
          col_map_data_o = wdata[7:0];
        end
        pready_o = 1'b1;
        state_nx = IDLE;
      end
      RD_WAIT: begin
        if (cnt == 2'd0) begin
          state_nx = write ? CT_WR : RESP;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      RESP: begin
        if (rgn == 2'b10) begin
          prdata_o = ch_t_rw_data_i[lsb +: 32];
        end else if (rgn == 2'b00) begin
          prdata_o = {24'd0, ch_map_data_i};
        end else begin
          prdata_o = {24'd0, col_map_data_i};
        end
        pready_o = 1'b1;
        state_nx = IDLE;
      end
      CT_WR: begin
        ch_t_rw_data_o = merged;
        ch_t_rw_wen_o  = 1'b1;
        pready_o       = 1'b1;
        state_nx       = IDLE;
      end
      ERR: begin
        pready_o  = 1'b1;
        pslverr_o = SLVERR;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
